// File: rtl/mtsp_gscs_counter_bank_pkg.sv
// Shared definitions for the coordinate counter bank: channel indices,
// lane packing helper and the per-channel command priority encoding.
package mtsp_gscs_counter_bank_pkg;

    typedef enum int {
        CH_X = 0,
        CH_Y = 1,
        CH_Z = 2,
        CH_W = 3
    } ch_idx_e;

    typedef enum logic [1:0] {
        CMD_NONE = 2'd0,
        CMD_INC  = 2'd1,
        CMD_LOAD = 2'd2,
        CMD_RST  = 2'd3
    } cmd_e;

    // Clear beats load beats increment; the increment input already folds in carry.
    function automatic cmd_e decode_cmd(input logic rst_req, input logic load_req,
                                        input logic inc_req);
        if (rst_req)
            return CMD_RST;
        else if (load_req)
            return CMD_LOAD;
        else if (inc_req)
            return CMD_INC;
        else
            return CMD_NONE;
    endfunction

    function automatic int lane_lsb(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/mtsp_gscs_counter_bank_counter.sv
// One coordinate channel: clear/load/increment with load clamping,
// wrap or saturate at the terminal value, and a same-cycle carry-out.
module mtsp_gscs_counter_bank_counter
    import mtsp_gscs_counter_bank_pkg::*;
#(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 rst_req,
    input  logic                 load_req,
    input  logic                 inc_req,
    input  logic                 carry_in,
    input  logic [CNT_WIDTH-1:0] load_data,
    input  logic [CNT_WIDTH-1:0] limit,
    input  logic                 sat_mode,
    output logic [CNT_WIDTH-1:0] coord,
    output logic                 wrap,
    output logic                 carry_out,
    output logic                 at_limit
);

    cmd_e                 cmd;
    logic [CNT_WIDTH-1:0] coord_next;
    logic                 terminal_hit;

    assign cmd      = decode_cmd(rst_req, load_req, inc_req | carry_in);
    assign at_limit = (coord == limit);

    // A count sitting above a freshly lowered limit is treated as terminal,
    // so the next increment wraps or saturates instead of running past it.
    always_comb begin
        coord_next   = coord;
        terminal_hit = 1'b0;
        if (en) begin
            unique case (cmd)
                CMD_RST:  coord_next = '0;
                CMD_LOAD: coord_next = (load_data > limit) ? limit : load_data;
                CMD_INC: begin
                    if (coord >= limit) begin
                        terminal_hit = 1'b1;
                        coord_next   = sat_mode ? limit : '0;
                    end else begin
                        coord_next = coord + 1'b1;
                    end
                end
                default: coord_next = coord;
            endcase
        end
    end

    assign carry_out = terminal_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coord <= '0;
            wrap  <= 1'b0;
        end else begin
            coord <= coord_next;
            wrap  <= terminal_hit;
        end
    end

endmodule

// File: rtl/mtsp_gscs_counter_bank.sv
// Bank of CH_COUNT coordinate counters (X,Y,Z,W) with optional
// combinational carry cascade from channel i-1 into channel i.
module mtsp_gscs_counter_bank
    import mtsp_gscs_counter_bank_pkg::*;
#(
    parameter int CH_COUNT  = 4,
    parameter int CNT_WIDTH = 8,
    parameter int CASCADE   = 0
) (
    input  logic                          CLK,
    input  logic                          nRST,
    input  logic                          EN,
    input  logic [CH_COUNT-1:0]           RST_MASK,
    input  logic [CH_COUNT-1:0]           INC_MASK,
    input  logic [CH_COUNT-1:0]           LOAD_MASK,
    input  logic [CH_COUNT*CNT_WIDTH-1:0] LOAD_DATA,
    input  logic [CH_COUNT*CNT_WIDTH-1:0] LIMIT,
    input  logic [CH_COUNT-1:0]           SAT_MODE,
    output logic [CH_COUNT*CNT_WIDTH-1:0] COORD,
    output logic [CH_COUNT-1:0]           WRAP,
    output logic [CH_COUNT-1:0]           AT_LIMIT
);

    // The top channel's carry has no consumer (nor any carry without cascade).
    logic [CH_COUNT-1:0] unused_carry;

    for (genvar i = 0; i < CH_COUNT; i++) begin : g_ch
        logic carry_in;
        logic carry_out;

        if (CASCADE != 0 && i > CH_X) begin : g_casc
            assign carry_in = g_ch[i-1].carry_out;
        end else begin : g_nocasc
            assign carry_in = 1'b0;
        end

        mtsp_gscs_counter_bank_counter #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_counter (
            .clk       (CLK),
            .rst_n     (nRST),
            .en        (EN),
            .rst_req   (RST_MASK[i]),
            .load_req  (LOAD_MASK[i]),
            .inc_req   (INC_MASK[i]),
            .carry_in  (carry_in),
            .load_data (LOAD_DATA[lane_lsb(i, CNT_WIDTH) +: CNT_WIDTH]),
            .limit     (LIMIT[lane_lsb(i, CNT_WIDTH) +: CNT_WIDTH]),
            .sat_mode  (SAT_MODE[i]),
            .coord     (COORD[lane_lsb(i, CNT_WIDTH) +: CNT_WIDTH]),
            .wrap      (WRAP[i]),
            .carry_out (carry_out),
            .at_limit  (AT_LIMIT[i])
        );

        assign unused_carry[i] = carry_out;
    end

endmodule

// File: tb/tb_mtsp_gscs_counter_bank.sv
// Directed bench for the coordinate counter bank: a vector table on a
// non-cascaded instance plus hand sequences for async reset and cascade.
module tb_mtsp_gscs_counter_bank;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        EN;
    logic [3:0]  RST_MASK, INC_MASK, LOAD_MASK, SAT_MODE;
    logic [31:0] LOAD_DATA, LIMIT;
    logic [31:0] coord, coord_c;
    logic [3:0]  wrap, wrap_c, at_limit, at_limit_c;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        en;
        logic [3:0]  rst_m;
        logic [3:0]  inc_m;
        logic [3:0]  load_m;
        logic [31:0] load_d;
        logic [31:0] limit;
        logic [3:0]  sat;
        logic [31:0] exp_coord;
        logic [3:0]  exp_wrap;
        logic [3:0]  exp_at;
    } vec_t;

    vec_t vecs[13];

    always #5 CLK = ~CLK;

    mtsp_gscs_counter_bank #(.CH_COUNT(4), .CNT_WIDTH(8), .CASCADE(0)) dut (
        .CLK(CLK), .nRST(nRST), .EN(EN), .RST_MASK(RST_MASK), .INC_MASK(INC_MASK),
        .LOAD_MASK(LOAD_MASK), .LOAD_DATA(LOAD_DATA), .LIMIT(LIMIT), .SAT_MODE(SAT_MODE),
        .COORD(coord), .WRAP(wrap), .AT_LIMIT(at_limit)
    );

    mtsp_gscs_counter_bank #(.CH_COUNT(4), .CNT_WIDTH(8), .CASCADE(1)) dut_c (
        .CLK(CLK), .nRST(nRST), .EN(EN), .RST_MASK(RST_MASK), .INC_MASK(INC_MASK),
        .LOAD_MASK(LOAD_MASK), .LOAD_DATA(LOAD_DATA), .LIMIT(LIMIT), .SAT_MODE(SAT_MODE),
        .COORD(coord_c), .WRAP(wrap_c), .AT_LIMIT(at_limit_c)
    );

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [3:0] rst_m, input logic [3:0] inc_m,
                         input logic [3:0] load_m, input logic [31:0] load_d,
                         input logic [31:0] limit, input logic [3:0] sat);
        EN        = en;
        RST_MASK  = rst_m;
        INC_MASK  = inc_m;
        LOAD_MASK = load_m;
        LOAD_DATA = load_d;
        LIMIT     = limit;
        SAT_MODE  = sat;
    endtask

    task automatic applyStimulus(input vec_t v);
        drive(v.en, v.rst_m, v.inc_m, v.load_m, v.load_d, v.limit, v.sat);
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic checkOutput(input string tag, input vec_t v);
        checkValue({tag, " coord"}, coord, v.exp_coord);
        checkValue({tag, " wrap"}, {28'b0, wrap}, {28'b0, v.exp_wrap});
        checkValue({tag, " at_limit"}, {28'b0, at_limit}, {28'b0, v.exp_at});
    endtask

    initial begin
        //          en    rst      inc      load     load_d        limit         sat      coord         wrap     at
        vecs[0]  = '{1'b1, 4'b0000, 4'b0001, 4'b0000, 32'h00000000, 32'h14090203, 4'b0010, 32'h00000001, 4'b0000, 4'b0000};
        vecs[1]  = '{1'b1, 4'b0000, 4'b0011, 4'b0000, 32'h00000000, 32'h14090203, 4'b0010, 32'h00000102, 4'b0000, 4'b0000};
        vecs[2]  = '{1'b1, 4'b0000, 4'b0011, 4'b0000, 32'h00000000, 32'h14090203, 4'b0010, 32'h00000203, 4'b0000, 4'b0011};
        vecs[3]  = '{1'b1, 4'b0000, 4'b0011, 4'b0000, 32'h00000000, 32'h14090203, 4'b0010, 32'h00000200, 4'b0011, 4'b0010};
        vecs[4]  = '{1'b1, 4'b0000, 4'b0010, 4'b0000, 32'h00000000, 32'h14090203, 4'b0010, 32'h00000200, 4'b0010, 4'b0010};
        vecs[5]  = '{1'b1, 4'b0100, 4'b0100, 4'b0100, 32'h00070000, 32'h14090203, 4'b0010, 32'h00000200, 4'b0000, 4'b0010};
        vecs[6]  = '{1'b1, 4'b0000, 4'b0000, 4'b0100, 32'h000C0000, 32'h14090203, 4'b0010, 32'h00090200, 4'b0000, 4'b0110};
        vecs[7]  = '{1'b1, 4'b0000, 4'b0100, 4'b1000, 32'h05000000, 32'h14090203, 4'b0010, 32'h05000200, 4'b0100, 4'b0010};
        vecs[8]  = '{1'b0, 4'b1111, 4'b1111, 4'b1111, 32'hFFFFFFFF, 32'h14090203, 4'b0010, 32'h05000200, 4'b0000, 4'b0010};
        vecs[9]  = '{1'b1, 4'b0000, 4'b0001, 4'b0000, 32'h00000000, 32'h14090200, 4'b0010, 32'h05000200, 4'b0001, 4'b0011};
        vecs[10] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 32'h00000000, 32'h03090200, 4'b0010, 32'h05000200, 4'b0000, 4'b0011};
        vecs[11] = '{1'b1, 4'b0000, 4'b1000, 4'b0000, 32'h00000000, 32'h03090200, 4'b1010, 32'h03000200, 4'b1000, 4'b1011};
        vecs[12] = '{1'b1, 4'b1010, 4'b0000, 4'b0000, 32'h00000000, 32'h03090200, 4'b1010, 32'h00000000, 4'b0000, 4'b0001};

        nRST = 1'b0;
        drive(1'b0, 4'b0, 4'b0, 4'b0, 32'h0, 32'h0, 4'b0);
        repeat (2) @(negedge CLK);
        checkValue("reset coord", coord, 32'h0);
        checkValue("reset wrap", {28'b0, wrap}, 32'h0);
        checkValue("reset at_limit", {28'b0, at_limit}, 32'h0000000F);
        nRST = 1'b1;

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i), vecs[i]);
        end

        // Asynchronous reset mid-count, with a wrap pulse live
        drive(1'b1, 4'b0000, 4'b0010, 4'b0001, 32'h00000005, 32'hFFFF00FF, 4'b0000);
        @(posedge CLK);
        @(negedge CLK);
        checkValue("pre-reset coord", coord, 32'h00000005);
        checkValue("pre-reset wrap", {28'b0, wrap}, 32'h00000002);
        drive(1'b0, 4'b0, 4'b0, 4'b0, 32'h0, 32'hFFFF00FF, 4'b0);
        #2 nRST = 1'b0;
        #1;
        checkValue("async reset coord", coord, 32'h0);
        checkValue("async reset wrap", {28'b0, wrap}, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;
        drive(1'b1, 4'b0000, 4'b0001, 4'b0000, 32'h0, 32'hFFFF00FF, 4'b0000);
        @(posedge CLK);
        @(negedge CLK);
        checkValue("first edge after release coord", coord, 32'h00000001);

        // Cascade ripple on the CASCADE=1 instance, all limits at 1
        drive(1'b1, 4'b1111, 4'b0000, 4'b0000, 32'h0, 32'h01010101, 4'b0000);
        @(posedge CLK);
        @(negedge CLK);
        checkValue("cascade clear", coord_c, 32'h0);

        drive(1'b1, 4'b0000, 4'b0001, 4'b0000, 32'h0, 32'h01010101, 4'b0000);
        @(posedge CLK); @(negedge CLK);
        checkValue("cascade step1 coord", coord_c, 32'h00000001);
        checkValue("cascade step1 wrap", {28'b0, wrap_c}, 32'h0);
        @(posedge CLK); @(negedge CLK);
        checkValue("cascade step2 coord", coord_c, 32'h00000100);
        checkValue("cascade step2 wrap", {28'b0, wrap_c}, 32'h00000001);
        checkValue("no-cascade step2 coord", coord, 32'h00000000);
        @(posedge CLK); @(negedge CLK);
        checkValue("cascade step3 coord", coord_c, 32'h00000101);
        @(posedge CLK); @(negedge CLK);
        checkValue("cascade step4 coord", coord_c, 32'h00010000);
        checkValue("cascade step4 wrap", {28'b0, wrap_c}, 32'h00000003);
        @(posedge CLK); @(negedge CLK);
        checkValue("cascade step5 coord", coord_c, 32'h00010001);

        // X at its limit but loading: no carry into Y
        drive(1'b1, 4'b0000, 4'b0001, 4'b0001, 32'h0, 32'h01010101, 4'b0000);
        @(posedge CLK); @(negedge CLK);
        checkValue("load blocks carry coord", coord_c, 32'h00010000);
        checkValue("load blocks carry wrap", {28'b0, wrap_c}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mtsp_gscs_counter_bank.md
MTSP_GSCS_COUNTER_BANK -- requirements
Module: MTSP_GSCsCounterBank

Interface
REQ-001 SHALL have parameter CH_COUNT, default 4, meaning number of coordinate channels (X,Y,Z,W order, channel 0 = X).
REQ-002 SHALL have parameter CNT_WIDTH, default 8, meaning width of each coordinate counter.
REQ-003 SHALL have parameter CASCADE, default 0, meaning 1 = channel i also increments on a wrap of channel i-1.
REQ-004 SHALL have port CLK  input  1  the single clock; all state is on its rising edge.
REQ-005 SHALL have port nRST  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port EN  input  1  command valid, already gated by decode for scratch memory ops.
REQ-007 SHALL have port RST_MASK  input  CH_COUNT  per-channel clear request.
REQ-008 SHALL have port INC_MASK  input  CH_COUNT  per-channel increment request.
REQ-009 SHALL have port LOAD_MASK  input  CH_COUNT  per-channel load request.
REQ-010 SHALL have port LOAD_DATA  input  CH_COUNT*CNT_WIDTH  load values, channel i at bits [i*CNT_WIDTH +: CNT_WIDTH].
REQ-011 SHALL have port LIMIT  input  CH_COUNT*CNT_WIDTH  per-channel terminal value, same packing.
REQ-012 SHALL have port SAT_MODE  input  CH_COUNT  per-channel: 1 = saturate at LIMIT, 0 = wrap.
REQ-013 SHALL have port COORD  output  CH_COUNT*CNT_WIDTH  registered counter values.
REQ-014 SHALL have port WRAP  output  CH_COUNT  registered one-cycle pulse, channel wrapped or hit saturation.
REQ-015 SHALL have port AT_LIMIT  output  CH_COUNT  combinational flag, COORD[i] == LIMIT[i].

Function
REQ-016 Commands SHALL be sampled only when EN=1; EN=0 SHALL hold all counters and drive WRAP=0 next cycle.
REQ-017 Per-channel priority SHALL be RST > LOAD > INC (effective increment includes cascade carry).
REQ-018 RST SHALL set the counter to 0 on the next edge.
REQ-019 LOAD SHALL set the counter to LOAD_DATA[i]; values above LIMIT[i] SHALL be clamped to LIMIT[i].
REQ-020 Increment below LIMIT SHALL add 1 (modulo 2^CNT_WIDTH arithmetic never exceeded).
REQ-021 Increment at LIMIT with SAT_MODE=0 SHALL set the counter to 0 and pulse WRAP[i].
REQ-022 Increment at LIMIT with SAT_MODE=1 SHALL hold at LIMIT and pulse WRAP[i] every such cycle.
REQ-023 With CASCADE=1, carry into channel i SHALL be the same-cycle wrap/saturate event of channel i-1, rippled combinationally; INC_MASK[i] OR carry counts as a single increment.
REQ-024 A channel under RST or LOAD SHALL NOT generate a carry, even if INC was also requested.
REQ-025 Latency SHALL be one cycle: command on edge n appears on COORD and WRAP after edge n.
REQ-026 LIMIT=0 SHALL be legal: every increment wraps (or saturates) with WRAP pulse, COORD stays 0.
REQ-027 LIMIT or SAT_MODE changing mid-count SHALL take effect on the next command; no retroactive clamp.

Reset
REQ-028 nRST low SHALL asynchronously force COORD=0 and WRAP=0 regardless of CLK; AT_LIMIT follows.
REQ-029 Release of nRST SHALL be synchronous to CLK; an EN=1 command on the first edge after release SHALL execute.

Structure
REQ-030 Channel-mask index constants, packing helpers and the command-priority encoding SHALL live in the shared MTSP_GSCs_pkg package.
REQ-031 One channel SHALL be a sub-module MTSP_GSCsCounter (counter, clamp, wrap/sat, carry-out), instantiated CH_COUNT times via generate.

Verification
REQ-032 Reset: nRST low mid-count (COORD0=5) -> COORD=0, WRAP=0 asynchronously, before next edge.
REQ-033 Wrap: LIMIT0=3, SAT=0, 4 INC on X -> COORD0 1,2,3,0; WRAP0 pulses only after the 4th.
REQ-034 Saturate: LIMIT1=2, SAT=1, 4 INC on Y -> COORD1 1,2,2,2; WRAP1 high after 3rd and 4th.
REQ-035 Cascade: CASCADE=1, LIMIT=all 1, INC X only for 4 cycles -> {W,Z,Y,X} 0001,0010,0011,0100 binary-per-channel; carries ripple same cycle.
REQ-036 Priority: RST, LOAD(7), INC same cycle on Z with LIMIT2=9 -> COORD2=0; LOAD(12) alone -> COORD2=9.
REQ-037 Hold: EN=0 with all masks set -> COORD unchanged, WRAP=0.
